// File: rtl/escalonador_rr.sv
// Round-robin process scheduler: counts retired instructions, preempts on quantum
// expiry or termination, and runs a req/ack context-swap handshake with the datapath.
// Optional macro ESCALONADOR_STATS_EN enables the saturating completed-swap counter.
module escalonador_rr #(
  parameter int unsigned NPROC   = 8,
  parameter int unsigned PID_W   = 3,
  parameter int unsigned QUANTUM = 16,
  parameter int unsigned QCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              instr_done,
  input  logic              pausaPC,
  input  logic              proc_fin,
  input  logic              new_valid,
  input  logic [PID_W-1:0]  new_pid,
  input  logic              swap_ack,
  output logic              swap_req,
  output logic [PID_W-1:0]  next_pid,
  output logic [PID_W-1:0]  cur_pid,
  output logic [QCNT_W-1:0] quantum_left,
  output logic              idle,
  output logic [15:0]       trocas_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PICK = 2'd2,
    S_SWAP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NPROC-1:0]    ready_q, ready_d;
  logic [PID_W-1:0]    cur_q, cur_d;
  logic [PID_W-1:0]    next_q, next_d;
  logic [QCNT_W-1:0]   ql_q, ql_d;
  logic                swap_req_q, swap_req_d;
  logic                idle_q, idle_d;
  logic                cand_hit;
  logic [PID_W-1:0]    cand_pid;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ready_q    <= NPROC'(1);
      cur_q      <= '0;
      next_q     <= '0;
      ql_q       <= QCNT_W'(QUANTUM);
      swap_req_q <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      cur_q      <= cur_d;
      next_q     <= next_d;
      ql_q       <= ql_d;
      swap_req_q <= swap_req_d;
      idle_q     <= idle_d;
    end
  end

  // First ready PID after cur_pid, wrapping; cur_pid itself is checked last
  always_comb begin : pick_search
    logic [PID_W-1:0] idx;
    cand_hit = 1'b0;
    cand_pid = cur_q;
    idx      = '0;
    for (int unsigned i = 1; i <= NPROC; i++) begin
      idx = PID_W'((32'(cur_q) + i) % NPROC);
      if (!cand_hit && ready_q[idx]) begin
        cand_hit = 1'b1;
        cand_pid = idx;
      end
    end
  end

  // Ready table: a termination clears, a new_valid sets, and the set wins
  always_comb begin
    ready_d = ready_q;
    if (state_q == S_RUN && proc_fin && cur_q != '0) begin
      ready_d[cur_q] = 1'b0;
    end
    if (new_valid) begin
      ready_d[new_pid] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    next_d     = next_q;
    ql_d       = ql_q;
    swap_req_d = 1'b0;
    idle_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && (ready_q != '0)) begin
          state_d = S_PICK;
        end
      end
      S_RUN: begin
        if (proc_fin) begin
          state_d = S_PICK;
        end else if (enable && instr_done && pausaPC) begin
          // Expiring retire keeps the count at 1; PICK or the swap reloads it
          if (ql_q == QCNT_W'(1)) begin
            state_d = S_PICK;
          end else begin
            ql_d = ql_q - QCNT_W'(1);
          end
        end
      end
      S_PICK: begin
        if (!cand_hit) begin
          state_d = S_IDLE;
        end else if (cand_pid != cur_q) begin
          next_d  = cand_pid;
          state_d = S_SWAP;
        end else begin
          ql_d    = QCNT_W'(QUANTUM);
          state_d = S_RUN;
        end
      end
      S_SWAP: begin
        if (swap_ack) begin
          cur_d   = next_q;
          ql_d    = QCNT_W'(QUANTUM);
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    swap_req_d = (state_d == S_SWAP);
    idle_d     = (state_d == S_IDLE);
  end

  assign swap_req     = swap_req_q;
  assign next_pid     = next_q;
  assign cur_pid      = cur_q;
  assign quantum_left = ql_q;
  assign idle         = idle_q;

`ifdef ESCALONADOR_STATS_EN
  logic             swap_done;
  logic [CNT_W-1:0] trocas_q;

  assign swap_done = (state_q == S_SWAP) && swap_ack;

  // Saturating count of completed swaps
  always_ff @(posedge clk) begin
    if (rst) begin
      trocas_q <= '0;
    end else if (swap_done && trocas_q != {CNT_W{1'b1}}) begin
      trocas_q <= trocas_q + CNT_W'(1);
    end
  end

  assign trocas_cnt = trocas_q;
`else
  assign trocas_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr: wake-up, expiry, wrap-around, I/O stall,
// termination with concurrent re-admission, and reset during a swap.
module tb_escalonador_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        instr_done;
  logic        pausaPC;
  logic        proc_fin;
  logic        new_valid;
  logic [2:0]  new_pid;
  logic        swap_ack;
  logic        swap_req;
  logic [2:0]  next_pid;
  logic [2:0]  cur_pid;
  logic [7:0]  quantum_left;
  logic        idle;
  logic [15:0] trocas_cnt;

  int n_cmp = 0;
  int n_err = 0;

  escalonador_rr dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .instr_done   (instr_done),
    .pausaPC      (pausaPC),
    .proc_fin     (proc_fin),
    .new_valid    (new_valid),
    .new_pid      (new_pid),
    .swap_ack     (swap_ack),
    .swap_req     (swap_req),
    .next_pid     (next_pid),
    .cur_pid      (cur_pid),
    .quantum_left (quantum_left),
    .idle         (idle),
    .trocas_cnt   (trocas_cnt)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_trocas(input int n);
`ifdef ESCALONADOR_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  // Run a full quantum, expect a swap to exp_next, optionally acknowledge it
  task automatic expire(input string tag, input logic [2:0] exp_next, input bit do_ack);
    instr_done = 1'b1;
    tick(15);
    check({tag, "_ql1"}, 32'(quantum_left), 32'd1);
    check({tag, "_noreq"}, 32'(swap_req), 32'd0);
    tick(1);
    instr_done = 1'b0;
    tick(1);
    check({tag, "_req"}, 32'(swap_req), 32'd1);
    check({tag, "_next"}, 32'(next_pid), 32'(exp_next));
    if (do_ack) begin
      swap_ack = 1'b1;
      tick(1);
      swap_ack = 1'b0;
      check({tag, "_cur"}, 32'(cur_pid), 32'(exp_next));
      check({tag, "_ql"}, 32'(quantum_left), 32'd16);
      check({tag, "_reqlow"}, 32'(swap_req), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    instr_done = 1'b0;
    pausaPC    = 1'b1;
    proc_fin   = 1'b0;
    new_valid  = 1'b0;
    new_pid    = 3'd0;
    swap_ack   = 1'b0;
    tick(2);
    check("rst_req", 32'(swap_req), 32'd0);
    check("rst_cur", 32'(cur_pid), 32'd0);
    check("rst_next", 32'(next_pid), 32'd0);
    check("rst_ql", 32'(quantum_left), 32'd16);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_trocas", 32'(trocas_cnt), 32'd0);
    rst = 1'b0;
    tick(2);
    check("dis_idle", 32'(idle), 32'd1);

    // 1: wake-up from IDLE to pid 3
    new_valid = 1'b1; new_pid = 3'd3; enable = 1'b1;
    tick(1);
    new_valid = 1'b0;
    check("t1_pick_idle", 32'(idle), 32'd0);
    check("t1_pick_req", 32'(swap_req), 32'd0);
    tick(1);
    check("t1_req", 32'(swap_req), 32'd1);
    check("t1_next", 32'(next_pid), 32'd3);
    check("t1_cur_old", 32'(cur_pid), 32'd0);
    tick(3);
    check("t1_hold", 32'(swap_req), 32'd1);
    swap_ack = 1'b1;
    tick(1);
    swap_ack = 1'b0;
    check("t1_cur", 32'(cur_pid), 32'd3);
    check("t1_ql", 32'(quantum_left), 32'd16);
    check("t1_reqlow", 32'(swap_req), 32'd0);
    check("t1_trocas", 32'(trocas_cnt), exp_trocas(1));

    // stray ack in RUN does nothing
    swap_ack = 1'b1;
    tick(1);
    swap_ack = 1'b0;
    check("ack_run_cur", 32'(cur_pid), 32'd3);
    check("ack_run_trocas", 32'(trocas_cnt), exp_trocas(1));

    // 2: ready {0,3}, expiry of pid 3 goes to pid 0
    expire("t2", 3'd0, 1'b1);
    check("t2_trocas", 32'(trocas_cnt), exp_trocas(2));

    // 3: ready {0,2,5}, rotation 5 -> 0 -> 2 -> 5
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t3_rst_trocas", 32'(trocas_cnt), 32'd0);
    new_valid = 1'b1; new_pid = 3'd5;
    tick(1);
    new_pid = 3'd2;
    tick(1);
    new_valid = 1'b0;
    check("t3_req", 32'(swap_req), 32'd1);
    check("t3_next", 32'(next_pid), 32'd5);
    swap_ack = 1'b1;
    tick(1);
    swap_ack = 1'b0;
    check("t3_cur", 32'(cur_pid), 32'd5);
    expire("t3_a", 3'd0, 1'b1);
    expire("t3_b", 3'd2, 1'b1);
    expire("t3_c", 3'd5, 1'b1);
    expire("t3_d", 3'd0, 1'b1);
    expire("t3_e", 3'd2, 1'b1);

    // 4: partial slice, then I/O stall and disable freeze the count
    instr_done = 1'b1;
    tick(7);
    check("t4_ql9", 32'(quantum_left), 32'd9);
    pausaPC = 1'b0;
    tick(50);
    check("t4_stall_ql", 32'(quantum_left), 32'd9);
    check("t4_stall_req", 32'(swap_req), 32'd0);
    check("t4_stall_cur", 32'(cur_pid), 32'd2);
    pausaPC = 1'b1; enable = 1'b0;
    tick(10);
    check("t4_dis_ql", 32'(quantum_left), 32'd9);
    check("t4_dis_idle", 32'(idle), 32'd0);
    instr_done = 1'b0; enable = 1'b1;

    // 5: termination with same-cycle re-admission keeps pid 2 ready
    proc_fin = 1'b1; new_valid = 1'b1; new_pid = 3'd2;
    tick(1);
    proc_fin = 1'b0; new_valid = 1'b0;
    tick(1);
    check("t5_req", 32'(swap_req), 32'd1);
    check("t5_next", 32'(next_pid), 32'd5);
    swap_ack = 1'b1;
    tick(1);
    swap_ack = 1'b0;
    check("t5_cur", 32'(cur_pid), 32'd5);
    expire("t5_a", 3'd0, 1'b1);
    expire("t5_b", 3'd2, 1'b1);
    // plain termination removes pid 2
    instr_done = 1'b1;
    tick(3);
    instr_done = 1'b0;
    proc_fin = 1'b1;
    tick(1);
    proc_fin = 1'b0;
    tick(1);
    check("t5_fin_next", 32'(next_pid), 32'd5);
    swap_ack = 1'b1;
    tick(1);
    swap_ack = 1'b0;
    check("t5_fin_cur", 32'(cur_pid), 32'd5);
    expire("t5_c", 3'd0, 1'b1);
    expire("t5_d", 3'd5, 1'b1);
    check("t5_trocas", 32'(trocas_cnt), exp_trocas(12));

    // 6: reset while a swap is pending
    expire("t6", 3'd0, 1'b0);
    tick(2);
    check("t6_hold", 32'(swap_req), 32'd1);
    rst = 1'b1; enable = 1'b0;
    tick(1);
    rst = 1'b0;
    check("t6_req", 32'(swap_req), 32'd0);
    check("t6_cur", 32'(cur_pid), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_ql", 32'(quantum_left), 32'd16);
    check("t6_trocas", 32'(trocas_cnt), 32'd0);
    tick(3);
    check("t6_stay_idle", 32'(idle), 32'd1);
    check("t6_stay_req", 32'(swap_req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
